// File: rtl/led_btn_if.sv
// Button-to-LED-driver bundle: three raw button levels in, three one-cycle
// event pulses plus a busy flag out.
interface led_btn_if;
  logic btn_next;
  logic btn_mode;
  logic btn_cyclic;
  logic next_led_re;
  logic change_mode_re;
  logic btn_cylic_re;
  logic busy;

  // Button side: drives the raw levels, watches the pulses
  modport master (
    output btn_next, btn_mode, btn_cyclic,
    input  next_led_re, change_mode_re, btn_cylic_re, busy
  );

  // Scheduler side: samples the raw levels, drives the pulses
  modport slave (
    input  btn_next, btn_mode, btn_cyclic,
    output next_led_re, change_mode_re, btn_cylic_re, busy
  );
endinterface

// File: rtl/led_btn_scheduler.sv
// Debounces three bouncing buttons and turns each accepted press into one
// registered pulse for the LED driver. A fixed-priority arbiter serialises
// simultaneous presses (change_mode > btn_cylic > next_led) so none is lost.
// Optional feature macro: LED_BTN_AUTOREPEAT_EN -- a held "next" button
// re-fires every REPEAT_CYCLES cycles after acceptance.

// Per-button lane: 2-flop synchronizer, debounce FSM and optional repeat timer.
// accept is high during the cycle whose closing edge accepts an event.
module led_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic btn_raw,
  output logic accept
);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} db_state_t;

  db_state_t  state;
  logic [1:0] sync_ff;
  logic [7:0] cnt;
  logic       s;
  logic       press_hit;
  logic       rpt_hit;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      (REPEAT_EN && (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535))) begin : g_param_chk
    $error("led_btn_debounce: parameter out of range");
  end

  assign s = sync_ff[1];

  // Press is accepted on the edge that would bring the count to DEBOUNCE_CYCLES
  always_comb press_hit = (state == DB_PRESS) && s && (cnt == DB_LAST);

  // Synchronizer plus debounce FSM; count restarts on every state change
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync_ff <= 2'b00;
      state   <= IDLE;
      cnt     <= 8'd0;
    end else begin
      sync_ff <= {sync_ff[0], btn_raw};
      case (state)
        IDLE: begin
          if (s) begin
            state <= DB_PRESS;
            cnt   <= 8'd0;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          if (!s) begin
            state <= DB_RELEASE;
            cnt   <= 8'd0;
          end
        end
        DB_RELEASE: begin
          if (s) begin
            state <= HELD;
            cnt   <= 8'd0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

`ifdef LED_BTN_AUTOREPEAT_EN
  logic [15:0] rpt_cnt;

  // Counts steady HELD cycles since acceptance (or since bouncing back into HELD)
  always_comb rpt_hit = REPEAT_EN && (state == HELD) && s &&
                        (rpt_cnt == 16'(REPEAT_CYCLES - 1));

  // Repeat timer; held at zero whenever the lane is not sitting in HELD
  always_ff @(posedge clk) begin
    if (sync_reset || !REPEAT_EN || state != HELD || !s)
      rpt_cnt <= 16'd0;
    else if (rpt_hit)
      rpt_cnt <= 16'd0;
    else
      rpt_cnt <= rpt_cnt + 16'd1;
  end
`else
  assign rpt_hit = 1'b0;
`endif

  assign accept = press_hit | rpt_hit;
endmodule

// Top: three debounce lanes feeding pending flags and a one-hot arbiter.
module led_btn_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic         clk,
  input  logic         sync_reset,
  led_btn_if.slave     bus
);
  // Lane index doubles as priority: higher index wins
  localparam int NUM_BTNS = 3;
  localparam int IDX_NEXT = 0;
  localparam int IDX_CYC  = 1;
  localparam int IDX_MODE = 2;

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] accept;
  logic [NUM_BTNS-1:0] pend;
  logic [NUM_BTNS-1:0] pend_nxt;
  logic [NUM_BTNS-1:0] grant;
  logic [NUM_BTNS-1:0] pulse;
  logic                busy_q;

  assign raw[IDX_NEXT] = bus.btn_next;
  assign raw[IDX_CYC]  = bus.btn_cyclic;
  assign raw[IDX_MODE] = bus.btn_mode;

  // Only the "next" lane is allowed to auto-repeat
  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_lane
    led_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (g == IDX_NEXT)
    ) u_db (
      .clk        (clk),
      .sync_reset (sync_reset),
      .btn_raw    (raw[g]),
      .accept     (accept[g])
    );
  end

  // Grant the highest pending flag; a new acceptance merges into its flag.
  // Granting only from registered flags keeps each event one full cycle in
  // pending before its pulse, which gives busy its one-cycle-per-event width.
  always_comb begin
    grant = '0;
    if (pend[IDX_MODE])      grant[IDX_MODE] = 1'b1;
    else if (pend[IDX_CYC])  grant[IDX_CYC]  = 1'b1;
    else if (pend[IDX_NEXT]) grant[IDX_NEXT] = 1'b1;
    pend_nxt = (pend & ~grant) | accept;
  end

  // Pending flags and registered outputs
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pend   <= '0;
      pulse  <= '0;
      busy_q <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      pulse  <= grant;
      busy_q <= |pend_nxt;
    end
  end

  assign bus.next_led_re    = pulse[IDX_NEXT];
  assign bus.btn_cylic_re   = pulse[IDX_CYC];
  assign bus.change_mode_re = pulse[IDX_MODE];
  assign bus.busy           = busy_q;
endmodule
